// File: rtl/tbu_pkg.sv
// tbu_pkg: shared widths, schedule lengths and FSM encoding for the traceback sequencer
package tbu_pkg;
  localparam int WD_STATE       = 8;
  localparam int WD_FSM         = 6;
  localparam int WD_RAM_DATA    = 1 << WD_STATE;
  localparam int WD_RAM_ADDRESS = WD_FSM;
  localparam int TRACE_DEPTH    = 32;
  localparam int DECODE_LEN     = 16;
  localparam int TBU_LAT        = 2;
  localparam int TOTAL          = TRACE_DEPTH + DECODE_LEN;
  localparam int WD_PHASE       = $clog2(DECODE_LEN);
  localparam int WD_FILL        = $clog2(TOTAL + 1);
  localparam int WD_CNT         = $clog2(TRACE_DEPTH > DECODE_LEN ? TRACE_DEPTH : DECODE_LEN);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_TRACE  = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  function automatic logic [WD_CNT-1:0] state_last(input logic [2:0] s);
    return s == S_TRACE ? WD_CNT'(TRACE_DEPTH - 1) :
           (s == S_DECODE || s == S_DRAIN) ? WD_CNT'(DECODE_LEN - 1) :
           s == S_FLUSH ? WD_CNT'(TBU_LAT - 1) : '0;
  endfunction
  function automatic logic [2:0] state_next(input logic [2:0] s);
    return s == S_INIT ? S_TRACE : s == S_TRACE ? S_DECODE : s == S_DECODE ? S_FLUSH :
           s == S_FLUSH ? S_DRAIN : S_IDLE;
  endfunction
endpackage

// File: rtl/tbu_sequencer_if.sv
// tbu_sequencer_if: ACS / traceback-unit side signals of the sequencer
interface tbu_sequencer_if;
  import tbu_pkg::*;
  logic                i_SymValid;
  logic [WD_STATE-1:0] i_BestState;
  logic                i_DecodedData;
  logic [WD_FSM-1:0]   o_WrCol;
  logic [WD_FSM-1:0]   o_RdCol;
  logic                o_TB_EN;
  logic                o_Init;
  logic                o_Hold;
  logic [WD_STATE-1:0] o_InitState;
  logic                o_DecBit;
  logic                o_DecValid;
  logic                o_Busy;
  logic                o_Overrun;
  modport master (output i_SymValid, i_BestState, i_DecodedData,
                  input o_WrCol, o_RdCol, o_TB_EN, o_Init, o_Hold, o_InitState,
                        o_DecBit, o_DecValid, o_Busy, o_Overrun);
  modport slave (input i_SymValid, i_BestState, i_DecodedData,
                 output o_WrCol, o_RdCol, o_TB_EN, o_Init, o_Hold, o_InitState,
                        o_DecBit, o_DecValid, o_Busy, o_Overrun);
endinterface

// File: rtl/tbu_lifo.sv
// tbu_lifo: 1-bit stack that turns newest-first decoded bits into time order
module tbu_lifo import tbu_pkg::*; #(
  parameter int DEPTH = DECODE_LEN
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_din,
  output logic o_dout,
  output logic o_empty,
  output logic o_full
);
  localparam int WP = $clog2(DEPTH) + 1;
  logic [DEPTH-1:0] r_mem;
  logic [WP-1:0]    r_ptr;
  logic [WP-2:0]    w_top;
  assign w_top   = r_ptr[WP-2:0] - 1'b1;
  assign o_empty = r_ptr == '0;
  assign o_full  = r_ptr == WP'(DEPTH);
  // storage needs no reset; only the pointer defines what is valid
  always_ff @(posedge i_Clock)
    if (i_push) r_mem[r_ptr[WP-2:0]] <= i_din;
  // stack pointer and registered top-of-stack read
  always_ff @(posedge i_Clock or negedge i_Reset)
    if (!i_Reset) begin
      r_ptr  <= '0;
      o_dout <= 1'b0;
    end else if (i_push) begin
      r_ptr  <= r_ptr + 1'b1;
    end else if (i_pop) begin
      r_ptr  <= r_ptr - 1'b1;
      o_dout <= r_mem[w_top];
    end
endmodule

// File: rtl/tbu_sequencer.sv
// tbu_sequencer: schedules traceback runs against the survivor RAM and reorders decoded bits
module tbu_sequencer import tbu_pkg::*; (
  input logic           i_Clock,
  input logic           i_Reset,
  tbu_sequencer_if.slave bus
);
  logic [WD_FSM-1:0]   r_wr_col, r_rd_col;
  logic [WD_FILL-1:0]  r_fill;
  logic [WD_PHASE-1:0] r_phase;
  logic [2:0]          r_state;
  logic [WD_CNT-1:0]   r_cnt;
  logic [WD_STATE-1:0] r_init_state;
  logic                r_overrun, r_dec_valid;
  logic [TBU_LAT-1:0]  r_hold_sr;
  logic w_trig, w_last, w_walk, w_hold, w_push, w_pop, w_empty, w_full, w_dout;
  assign w_trig = bus.i_SymValid && r_fill >= WD_FILL'(TOTAL - 1) &&
                  r_phase == WD_PHASE'(DECODE_LEN - 1);
  assign w_last = r_cnt == state_last(r_state);
  assign w_walk = r_state == S_INIT || r_state == S_TRACE || r_state == S_DECODE;
  assign w_hold = r_state == S_DECODE;
  assign w_push = r_hold_sr[TBU_LAT-1];
  assign w_pop  = r_state == S_DRAIN;
  assign bus.o_WrCol     = r_wr_col;
  assign bus.o_RdCol     = r_rd_col;
  assign bus.o_TB_EN     = w_walk || r_state == S_FLUSH;
  assign bus.o_Init      = r_state == S_INIT;
  assign bus.o_Hold      = w_hold;
  assign bus.o_InitState = r_init_state;
  assign bus.o_DecBit    = w_dout;
  assign bus.o_DecValid  = r_dec_valid;
  assign bus.o_Busy      = r_state != S_IDLE;
  assign bus.o_Overrun   = r_overrun;
  // ACS write tracking: column, saturating fill and decode phase advance per symbol
  always_ff @(posedge i_Clock or negedge i_Reset)
    if (!i_Reset) begin
      r_wr_col <= '0;
      r_fill   <= '0;
      r_phase  <= '0;
    end else if (bus.i_SymValid) begin
      r_wr_col <= r_wr_col + 1'b1;
      r_fill   <= r_fill == WD_FILL'(TOTAL) ? r_fill : r_fill + 1'b1;
      r_phase  <= r_phase == WD_PHASE'(DECODE_LEN - 1) ? '0 : r_phase + 1'b1;
    end
  // traceback schedule: start on trigger, walk RdCol backwards, drop triggers while busy
  always_ff @(posedge i_Clock or negedge i_Reset)
    if (!i_Reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rd_col     <= '0;
      r_init_state <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_trig && r_state == S_IDLE) begin
        r_state      <= S_INIT;
        r_cnt        <= '0;
        r_rd_col     <= r_wr_col;
        r_init_state <= bus.i_BestState;
      end else if (r_state != S_IDLE) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) r_state <= state_next(r_state);
        if (w_walk) r_rd_col <= r_rd_col - 1'b1;
      end
      if (w_trig && r_state != S_IDLE) r_overrun <= 1'b1;
    end
  // capture alignment: Hold delayed by the traceback latency marks valid DecodedData
  always_ff @(posedge i_Clock or negedge i_Reset)
    if (!i_Reset) begin
      r_hold_sr   <= '0;
      r_dec_valid <= 1'b0;
    end else begin
      r_hold_sr   <= {r_hold_sr[TBU_LAT-2:0], w_hold};
      r_dec_valid <= w_pop && !w_empty;
    end
  tbu_lifo u_lifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_push  (w_push && !w_full),
    .i_pop   (w_pop && !w_empty),
    .i_din   (bus.i_DecodedData),
    .o_dout  (w_dout),
    .o_empty (w_empty),
    .o_full  (w_full)
  );
endmodule

// File: tb/tb_tbu_sequencer.sv
// tb_tbu_sequencer: offset-based schedule model plus directed scenarios for the traceback sequencer
module tb_tbu_sequencer;
  localparam int TD    = 32;
  localparam int DL    = 16;
  localparam int LAT   = 2;
  localparam int O_DE  = TD + 1;
  localparam int O_FL  = TD + DL + 1;
  localparam int O_DR  = TD + DL + LAT + 1;
  localparam int O_END = O_DR + DL - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  tbu_sequencer_if bus();
  tbu_sequencer dut (.i_Clock(clk), .i_Reset(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  int checks = 0, passes = 0;
  int cyc = 0, t_trig = 0, sym = 0, dec_total = 0;
  bit active = 0, m_ovr = 0;
  logic [7:0]  m_init = '0;
  logic [5:0]  m_start = '0;
  logic [15:0] pat, dec_seq = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  function automatic int off();
    return active ? cyc - t_trig - 1 : -1;
  endfunction
  // model: traceback starts the cycle after an accepted trigger symbol; a busy sequencer drops it
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cyc = 0; sym = 0; active = 0; m_ovr = 0; m_init = '0; m_start = '0;
    end else begin
      if (bus.i_SymValid) begin
        sym++;
        if (sym >= TD + DL && sym % DL == 0) begin
          if (off() >= 0 && off() <= O_END) m_ovr = 1;
          else begin
            active = 1; t_trig = cyc; m_start = 6'((sym - 1) % 64); m_init = bus.i_BestState;
          end
        end
      end
      cyc++;
    end
  // traceback unit stand-in: bit k of the capture window is pat[15-k]
  always @(negedge clk) begin : tbu_drv
    int o;
    o = off();
    bus.i_DecodedData = (o >= O_DE + LAT && o < O_DE + LAT + DL) ? pat[DL - 1 - (o - O_DE - LAT)] : 1'($urandom);
  end
  // per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    int o;
    bit dv;
    o = off();
    dv = o > O_DR && o <= O_END + 1;
    chk("WrCol", bus.o_WrCol, sym % 64);
    chk("Busy", bus.o_Busy, 32'(o >= 0 && o <= O_END));
    chk("TB_EN", bus.o_TB_EN, 32'(o >= 0 && o < O_DR));
    chk("Init", bus.o_Init, 32'(o == 0));
    chk("Hold", bus.o_Hold, 32'(o >= O_DE && o < O_FL));
    chk("DecValid", bus.o_DecValid, 32'(dv));
    chk("Overrun", bus.o_Overrun, 32'(m_ovr));
    chk("InitState", bus.o_InitState, 32'(m_init));
    if (!active) chk("RdCol_idle", bus.o_RdCol, 0);
    else if (o >= 0 && o < O_FL) chk("RdCol", bus.o_RdCol, (int'(m_start) - o) & 63);
    if (dv) chk("DecBit", bus.o_DecBit, 32'(pat[o - O_DR - 1]));
    if (bus.o_DecValid) begin
      dec_total++;
      dec_seq = {dec_seq[14:0], bus.o_DecBit};
    end
  end
  // the stack must never overflow or underflow
  always @(posedge clk)
    if (rst_n) begin
      assert (!(dut.w_push && dut.w_full)) else begin checks++; $display("FAIL lifo_push_full at %0t", $time); end
      assert (!(dut.w_pop && dut.w_empty)) else begin checks++; $display("FAIL lifo_pop_empty at %0t", $time); end
    end
  task automatic sym_tx(input logic [7:0] b, input int gap);
    bus.i_SymValid = 1'b1;
    bus.i_BestState = b;
    @(negedge clk);
    bus.i_SymValid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask
  initial begin : timeout
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin : stim
    int base, n;
    bus.i_SymValid = 1'b1;
    bus.i_BestState = '0;
    pat = 16'h9D0D;
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("wrcol_held_in_reset", bus.o_WrCol, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("wrcol_after_release", bus.o_WrCol, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("wrcol_step", bus.o_WrCol, i);
    end
    bus.i_SymValid = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 4; i < 48; i++) sym_tx(8'($urandom), 5);
    sym_tx(8'hA5, 1);
    chk("init_first", bus.o_Init, 1);
    chk("initstate_a5", bus.o_InitState, 8'hA5);
    chk("rdcol_start47", bus.o_RdCol, 47);
    @(negedge clk);
    chk("rdcol_trace_first", bus.o_RdCol, 46);
    repeat (31) @(negedge clk);
    chk("rdcol_trace_last", bus.o_RdCol, 15);
    @(negedge clk);
    chk("hold_first", bus.o_Hold, 1);
    chk("rdcol_decode_first", bus.o_RdCol, 14);
    repeat (15) @(negedge clk);
    chk("rdcol_decode_last", bus.o_RdCol, 63);
    repeat (21) @(negedge clk);
    chk("decvalid_count_first", dec_total, 16);
    chk("decbit_reversed", dec_seq, 16'hB0B9);
    pat = 16'h3C5A;
    for (int i = 49; i < 80; i++) sym_tx(8'($urandom), 5);
    sym_tx(8'h5E, 1);
    chk("rdcol_start15", bus.o_RdCol, 15);
    repeat (15) @(negedge clk);
    chk("rdcol_wrap_0", bus.o_RdCol, 0);
    @(negedge clk);
    chk("rdcol_wrap_63", bus.o_RdCol, 63);
    chk("tben_across_wrap", bus.o_TB_EN, 1);
    @(negedge clk);
    chk("rdcol_wrap_62", bus.o_RdCol, 62);
    repeat (60) @(negedge clk);
    chk("overrun_clear", bus.o_Overrun, 0);
    base = dec_total;
    for (int i = 81; i <= 112; i++) sym_tx(8'($urandom), 2);
    chk("overrun_set", bus.o_Overrun, 1);
    repeat (60) @(negedge clk);
    chk("decvalid_count_overrun", dec_total - base, 16);
    chk("overrun_sticky", bus.o_Overrun, 1);
    for (int i = 113; i < 128; i++) sym_tx(8'($urandom), 5);
    sym_tx(8'h77, 1);
    n = 0;
    while (!bus.o_Hold && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_before_reset", bus.o_Hold, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("tben_async_reset", bus.o_TB_EN, 0);
    chk("hold_async_reset", bus.o_Hold, 0);
    chk("busy_async_reset", bus.o_Busy, 0);
    chk("overrun_async_reset", bus.o_Overrun, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    base = dec_total;
    @(negedge clk);
    for (int i = 1; i < 48; i++) sym_tx(8'($urandom), 5);
    chk("no_decvalid_after_reset", dec_total - base, 0);
    sym_tx(8'h3C, 1);
    chk("init_after_reset", bus.o_Init, 1);
    chk("initstate_3c", bus.o_InitState, 8'h3C);
    chk("rdcol_after_reset", bus.o_RdCol, 47);
    repeat (70) @(negedge clk);
    chk("decvalid_count_after_reset", dec_total - base, 16);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
